sprite_anim_seq: RTL and testbench
==================================

// Module: sprite_anim_seq
// PURPOSE
//  Parametrised dinosaur sprite animation sequencer. Maps game state and pose to the sprite select code.
//  Generates its own animation tick from a divider whose period shrinks with game speed.
//  Adds a death-blink sequence and tear-free output update aligned to the refresh pulse.
//  Feeds the sprite ROM address mux. Sits between the game-state FSM and the VGA renderer.
// PARAMETERS
//  SEL_W       4          select width; codes occupy bits [3:0], upper bits are always 0 (SEL_W>=4)
//  TICK_DIV    5_000_000  clk cycles per animation tick at speed 0
//  SPD_W       3          width of speed input
//  SPD_STEP    500_000    cycles removed from the period per speed level
//  MIN_DIV     1_000_000  lower clamp on the period (MIN_DIV>=2)
//  DEAD_BLINKS 3          visible/blank blink pairs after death
// PORTS
//  clk           in   1      system clock
//  rst           in   1      asynchronous, active-low reset
//  refresh_tick  in   1      1-cycle pulse at frame start; sel updates only on it
//  gamestate     in   2      00 unbegun, 01 running, 10 dead, 11 treated as 00
//  is_on_ground  in   1      dino on ground
//  is_lying      in   1      duck pose requested
//  speed         in   SPD_W  game speed level
//  sel           out  SEL_W  sprite select code (registered)
//  frame_strobe  out  1      1-cycle pulse, the cycle after sel changes value
//  anim_tick     out  1      1-cycle pulse on divider wrap
//  dead_done     out  1      high while in DEAD_HOLD
// BEHAVIOUR
//  Codes: DEFAULT 0000, DEAD 0001, DUCK_L 0010, DUCK_R 1011, RUN_L 0011, RUN_R 0111, BLANK 1111.
//  Reset (rst=0, async): state IDLE, phase 0, visible 1, divider 0, blink count 0; all outputs 0.
//  Period P = max(TICK_DIV - speed*SPD_STEP, MIN_DIV). Compute the product unclamped-width; no underflow wrap.
//  Divider: runs only in RUN, DUCK and DEAD_BLINK; cleared to 0 in all other states and on every state entry.
//   anim_tick=1 when cnt>=P-1; cnt then returns to 0. The >= covers P shrinking mid-count.
//  State, evaluated every clk with priority top-down:
//   gamestate 00/11      -> IDLE
//   10 from non-dead     -> DEAD_BLINK; visible=1, blink count=0
//   10 in DEAD_*         -> stay
//   01 & ~is_on_ground   -> AIR
//   01 & is_lying        -> DUCK
//   01 otherwise         -> RUN
//  Phase: RUN<->DUCK keeps phase and divider count, so the stride is continuous.
//   Any other entry into RUN/DUCK sets phase=0. In RUN/DUCK each anim_tick toggles phase.
//  DEAD_BLINK: each anim_tick toggles visible and increments blink count.
//   On the tick where count==2*DEAD_BLINKS-1 -> DEAD_HOLD, visible=1.
//  DEAD_BLINK/DEAD_HOLD leave only on gamestate 00/11; a re-entry into death restarts the blink.
//  Pending frame, taken from the registered state:
//   IDLE, AIR   -> DEFAULT
//   RUN         -> phase ? RUN_R : RUN_L
//   DUCK        -> phase ? DUCK_R : DUCK_L
//   DEAD_BLINK  -> visible ? DEAD : BLANK
//   DEAD_HOLD   -> DEAD
//  sel <= pending on clk edges where refresh_tick=1; otherwise hold.
//   Latency: input change sampled at edge k gives state at k; sel updates at the first refresh edge >= k+1.
//   If refresh_tick=1 every cycle, sel lags state by exactly 1 cycle.
//  frame_strobe: registered; 1 for one cycle after any edge where sel changed value; 0 on reset.
//  Simultaneous state change and refresh on one edge: sel takes the pre-edge state's frame.
//  Reset mid-sequence: outputs 0 at once; after release the block starts in IDLE.
// TESTING
//  Bench parameters: TICK_DIV=8, SPD_STEP=2, MIN_DIV=2, DEAD_BLINKS=2; refresh_tick=1 unless stated.
//  1 Reset: rst=0 mid-run -> sel=0000, frame_strobe=0, anim_tick=0 in the same cycle; after release with
//    gs=00 -> sel=0000.
//  2 Run: gs=01, ground=1, speed=0 -> sel 0011, then 0111 after 8 cycles, alternating every 8 cycles;
//    one frame_strobe per change.
//  3 Speed: speed=1 -> period 6; speed=3 -> 2; speed=7 -> clamped 2, no wrap.
//    Drop speed 0->3 at cnt=5 -> tick next cycle.
//  4 Death: gs 01->10 -> sel 0001, then 1111, 0001, 1111 every 8 cycles, then 0001 held; dead_done=1;
//    gs=00 -> sel 0000, dead_done=0.
//  5 Pose: in RUN with phase R, is_lying=1 -> sel 1011 next cycle with no phase reset.
//    ground=0 -> 0000; on landing, RUN_L restarts and the divider restarts.
//  6 Refresh gating: refresh_tick=0 for 20 cycles while running -> sel frozen, no strobe.
//    First refresh -> current pending frame.

Source files
------------

// File: rtl/sprite_anim_seq.sv
// Dinosaur sprite animation sequencer: maps game state and pose to a sprite select code.
// Includes a speed-scaled animation divider, a death-blink sequence and refresh-aligned select updates.
module sprite_anim_seq #(
    parameter int unsigned SEL_W       = 4,
    parameter int unsigned TICK_DIV    = 5_000_000,
    parameter int unsigned SPD_W       = 3,
    parameter int unsigned SPD_STEP    = 500_000,
    parameter int unsigned MIN_DIV     = 1_000_000,
    parameter int unsigned DEAD_BLINKS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refresh_tick,
    input  logic [1:0]       gamestate,
    input  logic             is_on_ground,
    input  logic             is_lying,
    input  logic [SPD_W-1:0] speed,
    output logic [SEL_W-1:0] sel,
    output logic             frame_strobe,
    output logic             anim_tick,
    output logic             dead_done
);
    localparam int unsigned MAX_DIV = (TICK_DIV > MIN_DIV) ? TICK_DIV : MIN_DIV;
    localparam int unsigned DIV_W   = $clog2(MAX_DIV + 1);
    localparam int unsigned BLK_MAX = 2 * DEAD_BLINKS - 1;
    localparam int unsigned BLK_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX + 1) : 1;

    localparam logic [3:0] F_DEFAULT = 4'b0000;
    localparam logic [3:0] F_DEAD    = 4'b0001;
    localparam logic [3:0] F_DUCK_L  = 4'b0010;
    localparam logic [3:0] F_DUCK_R  = 4'b1011;
    localparam logic [3:0] F_RUN_L   = 4'b0011;
    localparam logic [3:0] F_RUN_R   = 4'b0111;
    localparam logic [3:0] F_BLANK   = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DUCK,
        S_AIR,
        S_BLINK,
        S_HOLD
    } state_t;

    state_t           state, state_next;
    logic             phase, phase_next;
    logic             visible, visible_next;
    logic [BLK_W-1:0] blink, blink_next;
    logic [DIV_W-1:0] cnt, cnt_next;
    logic [63:0]      prod, period_full;
    logic             running, wrap, walk_cur, walk_nxt;
    logic [3:0]       pending;

    // Period computed wide so large speed*step never wraps below the clamp.
    always_comb begin
        prod        = 64'(speed) * 64'(SPD_STEP);
        period_full = (prod + 64'(MIN_DIV) >= 64'(TICK_DIV)) ? 64'(MIN_DIV)
                                                              : 64'(TICK_DIV) - prod;
        running     = (state == S_RUN) || (state == S_DUCK) || (state == S_BLINK);
        wrap        = running && (64'(cnt) + 64'd1 >= period_full);
    end

    always_comb begin
        state_next   = state;
        phase_next   = phase;
        visible_next = visible;
        blink_next   = blink;
        cnt_next     = (running && !wrap) ? cnt + DIV_W'(1) : '0;
        walk_cur     = (state == S_RUN) || (state == S_DUCK);
        case (gamestate)
            2'b01: begin
                if (!is_on_ground) begin
                    state_next = S_AIR;
                end else if (is_lying) begin
                    state_next = S_DUCK;
                end else begin
                    state_next = S_RUN;
                end
            end
            2'b10: begin
                if (state == S_BLINK) begin
                    if (wrap) begin
                        if (blink == BLK_W'(BLK_MAX)) begin
                            state_next   = S_HOLD;
                            visible_next = 1'b1;
                        end else begin
                            visible_next = ~visible;
                            blink_next   = blink + BLK_W'(1);
                        end
                    end
                end else if (state != S_HOLD) begin
                    state_next   = S_BLINK;
                    visible_next = 1'b1;
                    blink_next   = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase
        walk_nxt = (state_next == S_RUN) || (state_next == S_DUCK);
        // RUN<->DUCK keeps the stride; every other entry restarts divider and phase.
        if ((state_next != state) && !(walk_cur && walk_nxt)) begin
            cnt_next = '0;
        end
        if (walk_nxt) begin
            phase_next = walk_cur ? (phase ^ wrap) : 1'b0;
        end
    end

    always_comb begin
        pending = F_DEFAULT;
        case (state)
            S_RUN:   pending = phase ? F_RUN_R : F_RUN_L;
            S_DUCK:  pending = phase ? F_DUCK_R : F_DUCK_L;
            S_BLINK: pending = visible ? F_DEAD : F_BLANK;
            S_HOLD:  pending = F_DEAD;
            default: pending = F_DEFAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            phase        <= 1'b0;
            visible      <= 1'b1;
            blink        <= '0;
            cnt          <= '0;
            sel          <= '0;
            frame_strobe <= 1'b0;
            anim_tick    <= 1'b0;
            dead_done    <= 1'b0;
        end else begin
            state        <= state_next;
            phase        <= phase_next;
            visible      <= visible_next;
            blink        <= blink_next;
            cnt          <= cnt_next;
            anim_tick    <= wrap;
            dead_done    <= (state_next == S_HOLD);
            frame_strobe <= refresh_tick && (SEL_W'(pending) != sel);
            if (refresh_tick) begin
                sel <= SEL_W'(pending);
            end
        end
    end
endmodule

// File: tb/tb_sprite_anim_seq.sv
// Self-checking bench for sprite_anim_seq: behavioural model compared every cycle plus directed literal checks.
module tb_sprite_anim_seq;
    localparam int TB_TICK   = 8;
    localparam int TB_STEP   = 2;
    localparam int TB_MIN    = 2;
    localparam int TB_BLINKS = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DUCK  = 2;
    localparam int M_AIR   = 3;
    localparam int M_BLINK = 4;
    localparam int M_HOLD  = 5;

    logic       clk;
    logic       rst;
    logic       refresh_tick;
    logic [1:0] gamestate;
    logic       is_on_ground;
    logic       is_lying;
    logic [2:0] speed;
    logic [3:0] sel;
    logic       frame_strobe;
    logic       anim_tick;
    logic       dead_done;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    sprite_anim_seq #(
        .SEL_W(4), .TICK_DIV(TB_TICK), .SPD_W(3), .SPD_STEP(TB_STEP),
        .MIN_DIV(TB_MIN), .DEAD_BLINKS(TB_BLINKS)
    ) dut (
        .clk(clk), .rst(rst), .refresh_tick(refresh_tick), .gamestate(gamestate),
        .is_on_ground(is_on_ground), .is_lying(is_lying), .speed(speed),
        .sel(sel), .frame_strobe(frame_strobe), .anim_tick(anim_tick), .dead_done(dead_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int period_of(input int s);
        int p;
        p = TB_TICK - s * TB_STEP;
        return (p < TB_MIN) ? TB_MIN : p;
    endfunction

    function automatic logic [3:0] frame_of(input int mode, input int ph, input int vis);
        case (mode)
            M_RUN:   return (ph != 0) ? 4'b0111 : 4'b0011;
            M_DUCK:  return (ph != 0) ? 4'b1011 : 4'b0010;
            M_BLINK: return (vis != 0) ? 4'b0001 : 4'b1111;
            M_HOLD:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Reference model: mode, stride phase, blink progress and divider count as plain integers.
    int         m_mode = M_IDLE, m_phase = 0, m_vis = 1, m_blk = 0, m_cnt = 0;
    logic [3:0] m_sel = 4'b0000;
    logic       m_strobe = 1'b0, m_tick = 1'b0, m_done = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        int nxt, n_phase, n_vis, n_blk, n_cnt;
        bit tk, moving, walk_old, walk_new;
        logic [3:0] pend;
        if (!rst) begin
            m_mode <= M_IDLE; m_phase <= 0; m_vis <= 1; m_blk <= 0; m_cnt <= 0;
            m_sel <= 4'b0000; m_strobe <= 1'b0; m_tick <= 1'b0; m_done <= 1'b0;
        end else begin
            pend    = frame_of(m_mode, m_phase, m_vis);
            moving  = (m_mode == M_RUN) || (m_mode == M_DUCK) || (m_mode == M_BLINK);
            tk      = moving && (m_cnt >= period_of(int'(speed)) - 1);
            nxt     = m_mode;
            n_vis   = m_vis;
            n_blk   = m_blk;
            n_phase = m_phase;
            if (gamestate == 2'b01) begin
                nxt = !is_on_ground ? M_AIR : (is_lying ? M_DUCK : M_RUN);
            end else if (gamestate == 2'b10) begin
                if (m_mode != M_BLINK && m_mode != M_HOLD) begin
                    nxt = M_BLINK; n_vis = 1; n_blk = 0;
                end else if (m_mode == M_BLINK && tk) begin
                    if (m_blk == 2 * TB_BLINKS - 1) begin
                        nxt = M_HOLD; n_vis = 1;
                    end else begin
                        n_vis = 1 - m_vis; n_blk = m_blk + 1;
                    end
                end
            end else begin
                nxt = M_IDLE;
            end
            walk_old = (m_mode == M_RUN) || (m_mode == M_DUCK);
            walk_new = (nxt == M_RUN) || (nxt == M_DUCK);
            if (walk_new) n_phase = walk_old ? (m_phase ^ int'(tk)) : 0;
            if ((nxt != m_mode && !(walk_old && walk_new)) || tk || !moving) n_cnt = 0;
            else n_cnt = m_cnt + 1;
            m_mode <= nxt; m_phase <= n_phase; m_vis <= n_vis; m_blk <= n_blk; m_cnt <= n_cnt;
            m_tick   <= tk;
            m_done   <= (nxt == M_HOLD);
            m_strobe <= refresh_tick && (pend != m_sel);
            if (refresh_tick) m_sel <= pend;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_sel", 32'(sel), 32'(m_sel));
            check("cmp_strobe", 32'(frame_strobe), 32'(m_strobe));
            check("cmp_tick", 32'(anim_tick), 32'(m_tick));
            check("cmp_done", 32'(dead_done), 32'(m_done));
        end
    end

    task automatic at_next(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_change(input string name, input int exp);
        logic [3:0] cur;
        int c;
        cur = sel;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (sel == cur && c < 40);
        #2;
        if (exp < 0) check({name, "_timeout"}, 32'(c < 40), 32'd1);
        else check(name, 32'(c), 32'(exp));
    endtask

    task automatic wait_sel(input string name, input logic [3:0] code, input int bound);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (sel !== code && c < bound);
        #2;
        check(name, 32'(sel), 32'(code));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; refresh_tick = 1'b1; gamestate = 2'b00;
        is_on_ground = 1'b1; is_lying = 1'b0; speed = 3'd0;
        at_next(3);
        rst = 1'b1; cmp_en = 1'b1;
        at_next(2);
        check("reset_sel", 32'(sel), 32'h0);
        check("reset_done", 32'(dead_done), 32'h0);

        // Running stride at speed 0
        gamestate = 2'b01;
        wait_sel("run_start", 4'b0011, 5);
        wait_change("run_l_to_r", 8);
        check("run_r_code", 32'(sel), 32'h7);
        check("run_strobe", 32'(frame_strobe), 32'h1);
        wait_change("run_r_to_l", 8);

        // Speed-scaled period, clamp and mid-count shrink
        speed = 3'd1; wait_change("spd1_sync", -1); wait_change("spd1_period", 6);
        speed = 3'd3; wait_change("spd3_sync", -1); wait_change("spd3_period", 2);
        speed = 3'd7; wait_change("spd7_sync", -1); wait_change("spd7_period", 2);
        speed = 3'd0; wait_change("spd0_sync", -1); wait_change("spd0_period", 8);
        at_next(4);
        check("pre_drop_tick", 32'(anim_tick), 32'h0);
        speed = 3'd3;
        at_next(1);
        check("drop_tick", 32'(anim_tick), 32'h1);
        speed = 3'd0;

        // Pose changes
        wait_sel("pose_sync_r", 4'b0111, 20);
        is_lying = 1'b1;
        at_next(2);
        check("duck_r", 32'(sel), 32'hB);
        wait_change("duck_stride", 6);
        check("duck_l", 32'(sel), 32'h2);
        is_lying = 1'b0; is_on_ground = 1'b0;
        at_next(2);
        check("air_default", 32'(sel), 32'h0);
        at_next(1);
        is_on_ground = 1'b1;
        at_next(2);
        check("land_run_l", 32'(sel), 32'h3);
        wait_change("land_div_restart", 8);

        // Refresh gating
        at_next(4);
        refresh_tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            at_next(1);
            check("gate_sel", 32'(sel), 32'h7);
            check("gate_strobe", 32'(frame_strobe), 32'h0);
        end
        refresh_tick = 1'b1;
        at_next(1);
        check("refresh_first", 32'(sel), 32'h3);
        check("refresh_strobe", 32'(frame_strobe), 32'h1);

        // gamestate 11 behaves as unbegun
        gamestate = 2'b11;
        at_next(2);
        check("gs11_idle", 32'(sel), 32'h0);
        gamestate = 2'b01;
        wait_sel("rerun", 4'b0011, 5);

        // Death blink then hold
        gamestate = 2'b10;
        wait_sel("dead_first", 4'b0001, 5);
        wait_change("blink1", 8); check("blink1_code", 32'(sel), 32'hF);
        wait_change("blink2", 8); check("blink2_code", 32'(sel), 32'h1);
        wait_change("blink3", 8); check("blink3_code", 32'(sel), 32'hF);
        check("not_done_yet", 32'(dead_done), 32'h0);
        wait_change("hold_entry", 8);
        check("hold_code", 32'(sel), 32'h1);
        check("hold_done", 32'(dead_done), 32'h1);
        at_next(20);
        check("hold_sel_kept", 32'(sel), 32'h1);
        check("hold_done_kept", 32'(dead_done), 32'h1);
        gamestate = 2'b00;
        at_next(2);
        check("revive_sel", 32'(sel), 32'h0);
        check("revive_done", 32'(dead_done), 32'h0);

        // Asynchronous reset mid-run
        gamestate = 2'b01;
        wait_sel("pre_reset_run", 4'b0011, 5);
        at_next(8);
        check("pre_reset_r", 32'(sel), 32'h7);
        rst = 1'b0;
        #1;
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_strobe", 32'(frame_strobe), 32'h0);
        check("rst_tick", 32'(anim_tick), 32'h0);
        gamestate = 2'b00;
        at_next(2);
        rst = 1'b1;
        at_next(3);
        check("post_reset_sel", 32'(sel), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
